// File: rtl/riscv_control_sequencer.sv
// riscv_control_sequencer
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the RISC-V datapath with
// run/halt/single-step control, a retired-instruction counter and a sticky
// illegal-opcode trap.

module riscv_control_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic [6:0]       opcode,
    output logic             fetch_en,
    output logic             pc_en,
    output logic             regwrite_control,
    output logic             illegal_op,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        HALT   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        WB     = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             step_mode_q, step_mode_d;
    logic             halt_pending_q, halt_pending_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             opcode_legal;

    assign opcode_legal = (opcode == 7'h33) || (opcode == 7'h13) || (opcode == 7'h37);

    // Register all sequencer state; reset returns the core to a clean halt.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= HALT;
            step_mode_q    <= 1'b0;
            halt_pending_q <= 1'b0;
            illegal_q      <= 1'b0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            step_mode_q    <= step_mode_d;
            halt_pending_q <= halt_pending_d;
            illegal_q      <= illegal_d;
            count_q        <= count_d;
        end
    end

    // Next-state logic; unreachable encodings fall through to HALT.
    always_comb begin
        state_d     = HALT;
        step_mode_d = step_mode_q;
        illegal_d   = illegal_q;
        count_d     = count_q;
        case (state_q)
            HALT: begin
                if (!illegal_q) begin
                    if (run) begin
                        state_d     = FETCH;
                        step_mode_d = 1'b0;
                    end else if (step) begin
                        state_d     = FETCH;
                        step_mode_d = 1'b1;
                    end
                end
            end
            FETCH:  state_d = DECODE;
            DECODE: begin
                if (opcode_legal) begin
                    state_d = EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = HALT;
                end
            end
            EXEC:   state_d = WB;
            WB: begin
                count_d = count_q + CNT_W'(1);
                // A halt_req arriving during WB itself must still stop here.
                if (halt_pending_q || halt_req || step_mode_q || !run) begin
                    state_d = HALT;
                end else begin
                    state_d = FETCH;
                end
            end
            default: state_d = HALT;
        endcase
    end

    // Remember a halt request until the next instruction boundary reaches HALT.
    always_comb begin
        halt_pending_d = halt_pending_q;
        if (state_d == HALT) begin
            halt_pending_d = 1'b0;
        end else if ((state_q != HALT) && halt_req) begin
            halt_pending_d = 1'b1;
        end
    end

    assign fetch_en         = (state_q == FETCH);
    assign pc_en            = (state_q == WB);
    assign regwrite_control = (state_q == WB);
    assign halted           = (state_q == HALT);
    assign illegal_op       = illegal_q;
    assign state            = state_q;
    assign instr_count      = count_q;

endmodule

// File: tb/tb_riscv_control_sequencer.sv
// Directed testbench for riscv_control_sequencer. A second instance with a
// 4-bit counter shares all inputs so counter wrap can be observed quickly.

module tb_riscv_control_sequencer;

    logic        clk;
    logic        reset;
    logic        run;
    logic        step;
    logic        halt_req;
    logic [6:0]  opcode;
    logic        fetch_en, pc_en, regwrite_control, illegal_op, halted;
    logic [2:0]  state;
    logic [31:0] instr_count;
    logic        s_fetch_en, s_pc_en, s_regwrite_control, s_illegal_op, s_halted;
    logic [2:0]  s_state;
    logic [3:0]  s_instr_count;

    int checks = 0;
    int errors = 0;

    riscv_control_sequencer #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
        .opcode(opcode), .fetch_en(fetch_en), .pc_en(pc_en),
        .regwrite_control(regwrite_control), .illegal_op(illegal_op),
        .halted(halted), .state(state), .instr_count(instr_count)
    );

    riscv_control_sequencer #(.CNT_W(4)) dut_small (
        .clk(clk), .reset(reset), .run(run), .step(step), .halt_req(halt_req),
        .opcode(opcode), .fetch_en(s_fetch_en), .pc_en(s_pc_en),
        .regwrite_control(s_regwrite_control), .illegal_op(s_illegal_op),
        .halted(s_halted), .state(s_state), .instr_count(s_instr_count)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one cycle; outputs are sampled and inputs driven 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset across a couple of edges and release it with all inputs idle.
    task automatic do_reset();
        run = 1'b0; step = 1'b0; halt_req = 1'b0; opcode = 7'h33;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (state !== 3'd0 || halted !== 1'b1 || fetch_en !== 1'b0 || pc_en !== 1'b0 ||
            regwrite_control !== 1'b0 || illegal_op !== 1'b0 || instr_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL reset_values state=%0d halted=%0b fe=%0b pc=%0b rw=%0b ill=%0b cnt=%0d expected 0 1 0 0 0 0 0",
                     state, halted, fetch_en, pc_en, regwrite_control, illegal_op, instr_count);
        end
        run = 1'b1;
        for (int c = 1; c <= 4; c++) tick();
        checks++;
        if (state !== 3'd4 || regwrite_control !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_reach_wb state=%0d rw=%0b expected 4 1", state, regwrite_control);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || regwrite_control !== 1'b0 || pc_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async_in_wb state=%0d rw=%0b pc=%0b expected 0 0 0", state, regwrite_control, pc_en);
        end
        tick();
        run = 1'b0;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        checks++;
        if (state !== 3'd0 || instr_count !== 32'd0 || halted !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_post_release state=%0d cnt=%0d halted=%0b expected 0 0 1", state, instr_count, halted);
        end
    endtask

    task automatic test_continuous();
        logic exp_fe, exp_wb;
        do_reset();
        opcode = 7'h33;
        run = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            tick();
            exp_fe = (c == 1) || (c == 5) || (c == 9);
            exp_wb = (c == 4) || (c == 8);
            checks++;
            if (fetch_en !== exp_fe || pc_en !== exp_wb || regwrite_control !== exp_wb) begin
                errors++;
                $display("[TB] FAIL continuous_cycle%0d fe=%0b pc=%0b rw=%0b expected %0b %0b %0b",
                         c, fetch_en, pc_en, regwrite_control, exp_fe, exp_wb, exp_wb);
            end
        end
        checks++;
        if (instr_count !== 32'd2) begin
            errors++;
            $display("[TB] FAIL continuous_count got %0d expected 2", instr_count);
        end
        run = 1'b0;
        for (int c = 10; c <= 13; c++) tick();
        checks++;
        if (halted !== 1'b1 || instr_count !== 32'd3) begin
            errors++;
            $display("[TB] FAIL continuous_stop halted=%0b cnt=%0d expected 1 3", halted, instr_count);
        end
    endtask

    task automatic test_single_step();
        do_reset();
        opcode = 7'h13;
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) tick();
            checks++;
            if (state !== 3'(c) || instr_count !== 32'd0) begin
                errors++;
                $display("[TB] FAIL step_cycle%0d state=%0d cnt=%0d expected %0d 0", c, state, instr_count, c);
            end
        end
        tick();
        checks++;
        if (halted !== 1'b1 || instr_count !== 32'd1) begin
            errors++;
            $display("[TB] FAIL step_retire halted=%0b cnt=%0d expected 1 1", halted, instr_count);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (fetch_en !== 1'b0 || halted !== 1'b1) begin
                errors++;
                $display("[TB] FAIL step_idle fe=%0b halted=%0b expected 0 1", fetch_en, halted);
            end
        end
    endtask

    task automatic test_halt_req();
        do_reset();
        opcode = 7'h37;
        run = 1'b1;
        for (int c = 1; c <= 3; c++) tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checks++;
        if (state !== 3'd4) begin
            errors++;
            $display("[TB] FAIL halt_req_wb state=%0d expected 4", state);
        end
        tick();
        checks++;
        if (halted !== 1'b1 || fetch_en !== 1'b0 || instr_count !== 32'd1) begin
            errors++;
            $display("[TB] FAIL halt_req_exec halted=%0b fe=%0b cnt=%0d expected 1 0 1", halted, fetch_en, instr_count);
        end
        // run is still high, so the core restarts; now request halt during WB itself
        for (int c = 6; c <= 9; c++) tick();
        checks++;
        if (state !== 3'd4) begin
            errors++;
            $display("[TB] FAIL halt_req_restart state=%0d expected 4", state);
        end
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        checks++;
        if (halted !== 1'b1 || fetch_en !== 1'b0 || instr_count !== 32'd2) begin
            errors++;
            $display("[TB] FAIL halt_req_in_wb halted=%0b fe=%0b cnt=%0d expected 1 0 2", halted, fetch_en, instr_count);
        end
        run = 1'b0;
    endtask

    task automatic test_illegal();
        do_reset();
        opcode = 7'h63;
        run = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (pc_en !== 1'b0 || regwrite_control !== 1'b0) begin
                errors++;
                $display("[TB] FAIL illegal_no_commit cycle%0d pc=%0b rw=%0b expected 0 0", c, pc_en, regwrite_control);
            end
        end
        checks++;
        if (illegal_op !== 1'b1 || halted !== 1'b1 || instr_count !== 32'd0) begin
            errors++;
            $display("[TB] FAIL illegal_trap ill=%0b halted=%0b cnt=%0d expected 1 1 0", illegal_op, halted, instr_count);
        end
        opcode = 7'h33;
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        checks++;
        if (halted !== 1'b1 || fetch_en !== 1'b0 || illegal_op !== 1'b1) begin
            errors++;
            $display("[TB] FAIL illegal_sticky halted=%0b fe=%0b ill=%0b expected 1 0 1", halted, fetch_en, illegal_op);
        end
        do_reset();
        checks++;
        if (illegal_op !== 1'b0) begin
            errors++;
            $display("[TB] FAIL illegal_cleared got %0b expected 0", illegal_op);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        opcode = 7'h33;
        run = 1'b1;
        for (int c = 1; c <= 61; c++) tick();
        checks++;
        if (s_instr_count !== 4'd15 || instr_count !== 32'd15) begin
            errors++;
            $display("[TB] FAIL wrap_fifteen small=%0d wide=%0d expected 15 15", s_instr_count, instr_count);
        end
        for (int c = 62; c <= 65; c++) tick();
        checks++;
        if (s_instr_count !== 4'd0 || instr_count !== 32'd16) begin
            errors++;
            $display("[TB] FAIL wrap_zero small=%0d wide=%0d expected 0 16", s_instr_count, instr_count);
        end
        run = 1'b0;
    endtask

    // Run every scenario in order and print the summary.
    initial begin
        reset = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0; opcode = 7'h33;
        test_reset();
        test_continuous();
        test_single_step();
        test_halt_req();
        test_illegal();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
